// File: rtl/mmu_sequencer_if.sv
// Handshake and buffer-control bundle for the systolic matrix-multiply sequencer.
// Ports (via modports):
//   start, num_vectors          request and batch length, from the controller side
//   busy, done                  sequencer status
//   wmem_rd_en, wmem_addr       weight buffer read port (1-cycle read latency)
//   wwrite                      per-PE weight-write enables for row 0
//   data_rd_en, data_addr       input-data buffer read port (1-cycle read latency)
//   active                      row-0 active input to the array
//   out_valid, out_addr         bottom-row result capture strobe and index
interface mmu_sequencer_if #(
   parameter int ARR_SIZE = 2,
   parameter int VEC_W    = 8,
   parameter int WADDR_W  = 4
);
   logic                start;
   logic [VEC_W-1:0]    num_vectors;
   logic                busy;
   logic                done;
   logic                wmem_rd_en;
   logic [WADDR_W-1:0]  wmem_addr;
   logic [ARR_SIZE-1:0] wwrite;
   logic                data_rd_en;
   logic [VEC_W-1:0]    data_addr;
   logic                active;
   logic                out_valid;
   logic [VEC_W-1:0]    out_addr;

   modport master (
      output start, num_vectors,
      input  busy, done, wmem_rd_en, wmem_addr, wwrite,
             data_rd_en, data_addr, active, out_valid, out_addr
   );

   modport slave (
      input  start, num_vectors,
      output busy, done, wmem_rd_en, wmem_addr, wwrite,
             data_rd_en, data_addr, active, out_valid, out_addr
   );
endinterface

// File: rtl/mmu_sequencer.sv
// Sequencer for the systolic matrix-multiply array: loads one weight tile
// (last row first), streams a batch of input vectors, raises result-capture
// strobes once data has crossed the array, then pulses done.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    mmu_sequencer_if slave (start/num_vectors in, all control out)
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | reading weight rows ARR_SIZE-1 down to 0
// STREAM | reading input vectors 0..N-1
// DRAIN  | waiting 2*ARR_SIZE+1 cycles for the last results to emerge
// DONE   | one-cycle completion, then back to IDLE
module mmu_sequencer #(
   parameter int ARR_SIZE = 2,
   parameter int VEC_W    = 8,
   parameter int WADDR_W  = 4
) (
   input  logic           clk,
   input  logic           reset,
   mmu_sequencer_if.slave bus
);
   localparam int L    = 2*ARR_SIZE + 1;
   localparam int DR_W = $clog2(L);

   typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [WADDR_W-1:0] w_cnt, w_cnt_nxt;
   logic [VEC_W-1:0]   d_cnt, d_cnt_nxt;
   logic [VEC_W-1:0]   n_lat, n_lat_nxt;
   logic [DR_W-1:0]    dr_cnt, dr_cnt_nxt;

   logic               busy_q, done_q, wrd_q, drd_q, wr_d;
   logic [WADDR_W-1:0] waddr_q;
   logic [VEC_W-1:0]   daddr_q, oaddr_q;
   logic [L-1:0]       pipe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         w_cnt  <= '0;
         d_cnt  <= '0;
         n_lat  <= '0;
         dr_cnt <= '0;
      end else begin
         state  <= state_nxt;
         w_cnt  <= w_cnt_nxt;
         d_cnt  <= d_cnt_nxt;
         n_lat  <= n_lat_nxt;
         dr_cnt <= dr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      w_cnt_nxt  = w_cnt;
      d_cnt_nxt  = d_cnt;
      n_lat_nxt  = n_lat;
      dr_cnt_nxt = dr_cnt;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.num_vectors != '0) begin
                  n_lat_nxt = bus.num_vectors;
                  w_cnt_nxt = WADDR_W'(ARR_SIZE - 1);
                  state_nxt = LOAD_W;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         LOAD_W: begin
            if (w_cnt == '0) begin
               d_cnt_nxt = '0;
               state_nxt = STREAM;
            end else begin
               w_cnt_nxt = w_cnt - WADDR_W'(1);
            end
         end
         STREAM: begin
            // compare against N-1 so N = 2^VEC_W-1 finishes without wrapping d_cnt
            if (d_cnt == n_lat - VEC_W'(1)) begin
               dr_cnt_nxt = DR_W'(L - 1);
               state_nxt  = DRAIN;
            end else begin
               d_cnt_nxt = d_cnt + VEC_W'(1);
            end
         end
         DRAIN: begin
            if (dr_cnt == '0) state_nxt = DONE;
            else              dr_cnt_nxt = dr_cnt - DR_W'(1);
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output stage: every output is a flop decoded from the current state, so
   // strobes trail the state by one cycle. wwrite and active are a further
   // cycle late to line up with the buffers' read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrd_q   <= 1'b0;
         waddr_q <= '0;
         drd_q   <= 1'b0;
         daddr_q <= '0;
         wr_d    <= 1'b0;
         pipe    <= '0;
         oaddr_q <= '0;
      end else begin
         busy_q  <= (state != IDLE);
         done_q  <= (state == DONE);
         wrd_q   <= (state == LOAD_W);
         waddr_q <= (state == LOAD_W) ? w_cnt : '0;
         drd_q   <= (state == STREAM);
         daddr_q <= (state == STREAM) ? d_cnt : '0;
         wr_d    <= wrd_q;
         pipe    <= {pipe[L-2:0], drd_q};
         if (done_q)        oaddr_q <= '0;
         else if (pipe[L-1]) oaddr_q <= oaddr_q + VEC_W'(1);
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.wmem_rd_en = wrd_q;
   assign bus.wmem_addr  = waddr_q;
   assign bus.wwrite     = {ARR_SIZE{wr_d}};
   assign bus.data_rd_en = drd_q;
   assign bus.data_addr  = daddr_q;
   assign bus.active     = pipe[0];
   assign bus.out_valid  = pipe[L-1];
   assign bus.out_addr   = oaddr_q;
endmodule
